// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
package imem_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  // True when the word index of a byte address lies inside the program array.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                         input int unsigned     depth_words);
    return ({2'b00, addr[XLEN-1:2]} < depth_words);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response buffer: synchronous FIFO with a flush that empties it in one edge.
module imem_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < CW'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; flush discards everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr] <= din;
  end

  assign valid = (count_q != '0);
  assign head  = mem_q[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: program array, fixed-latency read pipeline,
// credit-limited request acceptance and an in-order response buffer.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            req_ready,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_wdata
);

  localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int OCCW = $clog2(LATENCY + FIFO_DEPTH + 1);

  logic [XLEN-1:0]    mem [DEPTH_WORDS];
  logic [LATENCY-1:0] vld_p;
  logic [XLEN-1:0]    data_p [LATENCY];
  logic [LATENCY-1:0] err_p;

  logic               req_fire;
  logic               req_bad;
  logic [XLEN-1:0]    req_word;
  logic [OCCW-1:0]    inflight;
  logic [OCCW-1:0]    occupancy;
  logic [CNTW-1:0]    fifo_count;
  logic               fifo_valid;
  logic [XLEN:0]      fifo_head;
  logic [1:0]         unused_prog_lsb;

  // Byte-offset bits of load addresses carry no information for word writes.
  assign unused_prog_lsb = prog_addr[1:0];

  assign req_bad  = (req_addr[1:0] != 2'b00) || !addr_in_range(req_addr, DEPTH_WORDS);
  assign req_word = req_bad ? INSN_NOP : mem[req_addr[AW+1:2]];

  // Program load port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (prog_we && addr_in_range(prog_addr, DEPTH_WORDS))
      mem[prog_addr[AW+1:2]] <= prog_wdata;
  end

  // Count requests still travelling down the latency pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + OCCW'(vld_p[i]);
  end

  // Every accepted request owns a FIFO slot until it is popped, so the
  // buffer can never overflow.
  assign occupancy = inflight + OCCW'(fifo_count);
  assign req_ready = !reset && !flush && (occupancy < OCCW'(FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;

  // Stage 0 captures the array word at acceptance (pre-edge contents); valids shift each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= req_fire;
      for (int i = 1; i < LATENCY; i++)
        vld_p[i] <= vld_p[i-1];
    end
  end

  // Data side of the latency pipeline, qualified by vld_p.
  always_ff @(posedge clk) begin
    data_p[0] <= req_word;
    err_p[0]  <= req_bad;
    for (int i = 1; i < LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  // Last pipeline stage feeds the in-order response buffer.
  imem_rsp_fifo #(
    .WIDTH (XLEN + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (vld_p[LATENCY-1]),
    .din   ({err_p[LATENCY-1], data_p[LATENCY-1]}),
    .pop   (rsp_valid && rsp_ready),
    .valid (fifo_valid),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Outputs read as zero whenever no response is held, including under reset.
  assign rsp_valid = fifo_valid;
  assign rsp_data  = fifo_valid ? fifo_head[XLEN-1:0] : '0;
  assign rsp_err   = fifo_valid & fifo_head[XLEN];

endmodule
